// File: rtl/hazard_pkg.sv
// Shared definitions for the D-stage hazard scoreboard.
// Holds the Tuse/Tnew classification codes produced by the D-stage decoder,
// the register-file forward select code and the default MDU latencies.
package hazard_pkg;

  // Tuse: cycles from D until the operand is consumed; all-ones = not read
  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_M    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'b11;

  // Tnew: cycles after entering E until the result can be forwarded
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;
  localparam logic [1:0] TNEW_PC8  = 2'd0;

  // forward select 0 takes the operand from the register file
  localparam int FWD_RF = 0;

  localparam int DEF_MUL_LAT = 5;
  localparam int DEF_DIV_LAT = 10;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage <-> hazard scoreboard bundle.
// master: the D-stage decoder (drives instruction classification and flush,
//         receives stall / forward selects / MDU busy).
// slave : the scoreboard.
interface hazard_scoreboard_if #(
  parameter int TW = 2,
  parameter int FW = 2
);
  logic          d_valid;
  logic [4:0]    d_rs;
  logic [4:0]    d_rt;
  logic [TW-1:0] d_tuse_rs;
  logic [TW-1:0] d_tuse_rt;
  logic [4:0]    d_dst;
  logic [TW-1:0] d_tnew;
  logic          d_md_start;
  logic          d_md_div;
  logic          d_md_use;
  logic          flush;
  logic          stall;
  logic [FW-1:0] fwd_rs;
  logic [FW-1:0] fwd_rt;
  logic          mdu_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
           d_md_start, d_md_div, d_md_use, flush,
    input  stall, fwd_rs, fwd_rt, mdu_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
           d_md_start, d_md_div, d_md_use, flush,
    output stall, fwd_rs, fwd_rt, mdu_busy
  );
endinterface

// File: rtl/mdu_busy_counter.sv
// MDU busy counter: loads a latency when a multiply/divide starts, then
// counts down to zero. busy is high while the count is nonzero.
// Ports: clk, reset (async, active-low), load, load_val[CW-1:0], busy.
module mdu_busy_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          busy
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/forward controller for the 5-stage MIPS pipeline.
// Tracks the destination and remaining Tnew of every instruction in the
// NSTAGE stages behind D, compares them against the D-stage sources and
// their Tuse, and drives the D stall plus the forward-select muxes.
// An MDU busy counter blocks mult/div starts and hi/lo accesses while a
// previous MDU operation is still running.
// Ports: clk, reset (async, active-low), bus (hazard_scoreboard_if.slave).
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NSTAGE  = 3,
  parameter int TW      = 2,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CW      = 4,
  parameter int FW      = $clog2(NSTAGE + 1)
) (
  input  logic              clk,
  input  logic              reset,
  hazard_scoreboard_if.slave bus
);

  typedef struct packed {
    logic          stall;
    logic [FW-1:0] fwd;
  } src_res_t;

  logic          valid_q [1:NSTAGE];
  logic          valid_d [1:NSTAGE];
  logic [4:0]    dst_q   [1:NSTAGE];
  logic [4:0]    dst_d   [1:NSTAGE];
  logic [TW-1:0] tnew_q  [1:NSTAGE];
  logic [TW-1:0] tnew_d  [1:NSTAGE];

  src_res_t      rs_res;
  src_res_t      rt_res;
  logic          md_busy;
  logic          md_stall;
  logic          stall;
  logic          insert;
  logic          md_load;
  logic [CW-1:0] md_load_val;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Scan oldest to youngest so the youngest matching entry is the one kept.
  function automatic src_res_t lookup(input logic [4:0] src, input logic [TW-1:0] tuse);
    src_res_t      r;
    logic          hit;
    logic [TW-1:0] hit_tnew;
    logic [FW-1:0] hit_k;
    hit      = 1'b0;
    hit_tnew = '0;
    hit_k    = '0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (valid_q[k] && (dst_q[k] == src) && (dst_q[k] != 5'd0)) begin
        hit      = 1'b1;
        hit_tnew = tnew_q[k];
        hit_k    = FW'(k);
      end
    end
    r.stall = hit && (tuse != '1) && (hit_tnew > tuse);
    r.fwd   = (hit && (tuse != '1) && (hit_tnew == '0)) ? hit_k : FW'(FWD_RF);
    return r;
  endfunction

  always_comb begin
    rs_res   = lookup(bus.d_rs, bus.d_tuse_rs);
    rt_res   = lookup(bus.d_rt, bus.d_tuse_rt);
    md_stall = (bus.d_md_start | bus.d_md_use) & bus.d_valid & md_busy;
    stall    = rs_res.stall | rt_res.stall | md_stall;
    // a flush squashes the D instruction as well as everything behind it
    insert   = bus.d_valid & ~stall & ~bus.flush;
    md_load  = insert & bus.d_md_start;
    md_load_val = bus.d_md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
  end

  always_comb begin
    for (int k = 1; k <= NSTAGE; k++) begin
      valid_d[k] = 1'b0;
      dst_d[k]   = '0;
      tnew_d[k]  = '0;
    end
    if (insert) begin
      valid_d[1] = 1'b1;
      dst_d[1]   = bus.d_dst;
      tnew_d[1]  = bus.d_tnew;
    end
    if (!bus.flush) begin
      for (int k = 2; k <= NSTAGE; k++) begin
        valid_d[k] = valid_q[k-1];
        dst_d[k]   = dst_q[k-1];
        tnew_d[k]  = sat_dec(tnew_q[k-1]);
      end
    end
  end

  // ---- stage register: entries advance one stage every cycle ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= NSTAGE; k++) begin
        valid_q[k] <= 1'b0;
        dst_q[k]   <= '0;
        tnew_q[k]  <= '0;
      end
    end else begin
      for (int k = 1; k <= NSTAGE; k++) begin
        valid_q[k] <= valid_d[k];
        dst_q[k]   <= dst_d[k];
        tnew_q[k]  <= tnew_d[k];
      end
    end
  end

  mdu_busy_counter #(.CW(CW)) u_mdu_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (md_load),
    .load_val (md_load_val),
    .busy     (md_busy)
  );

  assign bus.stall    = stall;
  assign bus.fwd_rs   = rs_res.fwd;
  assign bus.fwd_rt   = rt_res.fwd;
  assign bus.mdu_busy = md_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by
// random traffic, checked against an issue-history reference model.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NST = 3;

  logic clk;
  logic reset;

  hazard_scoreboard_if #(.TW(2), .FW(2)) bus_if ();

  hazard_scoreboard #(
    .NSTAGE(NST), .TW(2), .MUL_LAT(5), .DIV_LAT(10), .CW(4), .FW(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: history of issued instructions
  typedef struct {
    int cyc;
    int dst;
    int tnew;
  } rec_t;
  rec_t hist[$];
  int cyc       = 0;
  int flush_cyc = -1000;
  int md_s      = -1000;
  int md_lat    = 0;

  logic       c_v, c_ms, c_md, c_mu, c_fl;
  logic [4:0] c_rs, c_rt, c_dst;
  logic [1:0] c_urs, c_urt, c_tn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_d(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] urs, input logic [1:0] urt,
                       input logic [4:0] dst, input logic [1:0] tn,
                       input logic ms, input logic md, input logic mu, input logic fl);
    c_v = v; c_rs = rs; c_rt = rt; c_urs = urs; c_urt = urt; c_dst = dst; c_tn = tn;
    c_ms = ms; c_md = md; c_mu = mu; c_fl = fl;
    bus_if.d_valid    = v;
    bus_if.d_rs       = rs;
    bus_if.d_rt       = rt;
    bus_if.d_tuse_rs  = urs;
    bus_if.d_tuse_rt  = urt;
    bus_if.d_dst      = dst;
    bus_if.d_tnew     = tn;
    bus_if.d_md_start = ms;
    bus_if.d_md_div   = md;
    bus_if.d_md_use   = mu;
    bus_if.flush      = fl;
    #2;
  endtask

  // Youngest live instruction writing src decides; its Tnew has dropped by
  // one for every cycle spent beyond its first stage.
  function automatic void model_src(input int src, input int tuse, output logic st, output int fw);
    st = 1'b0;
    fw = 0;
    if (tuse == 3 || src == 0) return;
    for (int age = 1; age <= NST; age++) begin
      foreach (hist[i]) begin
        if (cyc - hist[i].cyc == age && hist[i].cyc > flush_cyc && hist[i].dst == src) begin
          int eff;
          eff = hist[i].tnew - (age - 1);
          if (eff < 0) eff = 0;
          st = (eff > tuse);
          fw = (eff == 0) ? age : 0;
          return;
        end
      end
    end
  endfunction

  function automatic logic model_busy();
    return (cyc - md_s >= 1) && (cyc - md_s <= md_lat);
  endfunction

  function automatic logic model_stall();
    logic s1, s2;
    int f1, f2;
    model_src(int'(c_rs), int'(c_urs), s1, f1);
    model_src(int'(c_rt), int'(c_urt), s2, f2);
    return s1 | s2 | (c_v & (c_ms | c_mu) & model_busy());
  endfunction

  // compare current outputs with the model, then advance one clock
  task automatic tick();
    logic s1, s2, st_e;
    int f1, f2;
    model_src(int'(c_rs), int'(c_urs), s1, f1);
    model_src(int'(c_rt), int'(c_urt), s2, f2);
    st_e = model_stall();
    chk("model_stall", bus_if.stall, st_e);
    chk("model_fwd_rs", bus_if.fwd_rs, f1[1:0]);
    chk("model_fwd_rt", bus_if.fwd_rt, f2[1:0]);
    chk("model_mdu_busy", bus_if.mdu_busy, model_busy());
    @(posedge clk);
    if (c_v && !st_e && !c_fl) begin
      hist.push_back('{cyc, int'(c_dst), int'(c_tn)});
      if (c_ms) begin
        md_s   = cyc;
        md_lat = c_md ? 10 : 5;
      end
    end
    if (c_fl) flush_cyc = cyc;
    cyc++;
    #1;
  endtask

  task automatic idle();
    set_d(0, 0, 0, TUSE_NONE, TUSE_NONE, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int stall_cnt;
    reset = 1'b0;
    idle();

    // reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      set_d(1'b1, 5'($urandom), 5'($urandom), 2'($urandom), 2'($urandom),
            5'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      chk("rst_stall", bus_if.stall, 0);
      chk("rst_fwd_rs", bus_if.fwd_rs, 0);
      chk("rst_fwd_rt", bus_if.fwd_rt, 0);
      chk("rst_busy", bus_if.mdu_busy, 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    cyc = 0;

    // add $8 (tnew 1) then beq $8 (tuse 0): one stall, then forward from 2
    set_d(1, 0, 0, TUSE_NONE, TUSE_NONE, 8, TNEW_ALU, 0, 0, 0, 0); tick();
    set_d(1, 8, 0, TUSE_D, TUSE_NONE, 0, 0, 0, 0, 0, 0);
    chk("beq_stall", bus_if.stall, 1); tick();
    set_d(1, 8, 0, TUSE_D, TUSE_NONE, 0, 0, 0, 0, 0, 0);
    chk("beq_nostall", bus_if.stall, 0);
    chk("beq_fwd", bus_if.fwd_rs, 2); tick();

    // lw $5 then addu reading $5 at tuse 1: exactly one stall cycle
    set_d(1, 0, 0, TUSE_NONE, TUSE_NONE, 5, TNEW_LOAD, 0, 0, 0, 0); tick();
    stall_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      set_d(1, 9, 5, TUSE_NONE, TUSE_E, 6, TNEW_ALU, 0, 0, 0, 0);
      if (!bus_if.stall) break;
      stall_cnt++;
      tick();
    end
    chk("lw_use_stalls", stall_cnt, 1);
    tick();

    // ori $9, lw $9, reader of $9 at tuse 1: stalls on the younger lw
    set_d(1, 0, 0, TUSE_NONE, TUSE_NONE, 9, TNEW_ALU, 0, 0, 0, 0); tick();
    set_d(1, 0, 0, TUSE_NONE, TUSE_NONE, 9, TNEW_LOAD, 0, 0, 0, 0); tick();
    set_d(1, 9, 0, TUSE_E, TUSE_NONE, 0, 0, 0, 0, 0, 0);
    chk("young_stall", bus_if.stall, 1); tick();
    set_d(1, 9, 0, TUSE_E, TUSE_NONE, 0, 0, 0, 0, 0, 0);
    chk("young_nostall", bus_if.stall, 0);
    chk("young_no_old_fwd", bus_if.fwd_rs, 0); tick();

    // lw $0 then a $0 reader at tuse 0
    set_d(1, 0, 0, TUSE_NONE, TUSE_NONE, 0, TNEW_LOAD, 0, 0, 0, 0); tick();
    set_d(1, 0, 0, TUSE_D, TUSE_D, 0, 0, 0, 0, 0, 0);
    chk("r0_stall", bus_if.stall, 0);
    chk("r0_fwd", bus_if.fwd_rs, 0); tick();

    // div, then mult at t+1, mflo afterwards, flush at t+3
    set_d(1, 0, 0, TUSE_NONE, TUSE_NONE, 0, 0, 1, 1, 0, 0); tick();
    stall_cnt = 0;
    for (int i = 1; i <= 11; i++) begin
      if (i == 1) set_d(1, 0, 0, TUSE_NONE, TUSE_NONE, 0, 0, 1, 0, 0, 0);
      else        set_d(1, 0, 0, TUSE_NONE, TUSE_NONE, 12, TNEW_ALU, 0, 0, 1, (i == 3));
      chk($sformatf("mdu_stall_%0d", i), bus_if.stall, (i <= 10));
      if (bus_if.stall) stall_cnt++;
      tick();
    end
    chk("mdu_stall_cycles", stall_cnt, 10);
    idle();
    chk("mdu_idle_busy", bus_if.mdu_busy, 0); tick();

    // flush with three live entries and a valid D instruction
    set_d(1, 0, 0, TUSE_NONE, TUSE_NONE, 10, TNEW_LOAD, 0, 0, 0, 0); tick();
    set_d(1, 0, 0, TUSE_NONE, TUSE_NONE, 11, TNEW_LOAD, 0, 0, 0, 0); tick();
    set_d(1, 0, 0, TUSE_NONE, TUSE_NONE, 12, TNEW_LOAD, 0, 0, 0, 0); tick();
    set_d(1, 0, 0, TUSE_NONE, TUSE_NONE, 13, TNEW_PC8, 0, 0, 0, 1); tick();
    set_d(1, 10, 13, TUSE_D, TUSE_D, 0, 0, 0, 0, 0, 0);
    chk("fl_stall_a", bus_if.stall, 0);
    chk("fl_fwd_rt_a", bus_if.fwd_rt, 0); tick();
    set_d(1, 11, 12, TUSE_D, TUSE_D, 0, 0, 0, 0, 0, 0);
    chk("fl_stall_b", bus_if.stall, 0);
    chk("fl_fwd_b", {bus_if.fwd_rs, bus_if.fwd_rt}, 0); tick();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_d(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
            2'($urandom), 2'($urandom), 5'($urandom_range(0, 5)), 2'($urandom),
            1'($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 24) == 0));
      tick();
    end

    // asynchronous reset in the middle of an MDU op with a pending hazard
    idle(); tick(); tick(); tick();
    set_d(1, 0, 0, TUSE_NONE, TUSE_NONE, 3, TNEW_LOAD, 1, 1, 0, 0); tick();
    set_d(1, 3, 0, TUSE_D, TUSE_NONE, 0, 0, 0, 0, 1, 0);
    chk("pre_rst_stall", bus_if.stall, 1);
    chk("pre_rst_busy", bus_if.mdu_busy, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_stall", bus_if.stall, 0);
    chk("mid_rst_busy", bus_if.mdu_busy, 0);
    chk("mid_rst_fwd", {bus_if.fwd_rs, bus_if.fwd_rt}, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
